// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 splitting router: flit layout, destination
// encodings and helpers for decoding a flit header.
package router_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 2;
    localparam int unsigned DEST_MSB   = 31;
    localparam int unsigned PRIO_BIT   = 29;
    localparam int unsigned NUM_PORTS  = 3;

    typedef logic [DATA_WIDTH-1:0] flit_t;

    typedef enum logic [1:0] {
        DEST_A    = 2'b00,
        DEST_B    = 2'b01,
        DEST_C    = 2'b10,
        DEST_DROP = 2'b11
    } dest_e;

    function automatic dest_e get_dest(input flit_t f);
        return dest_e'(f[DEST_MSB -: 2]);
    endfunction

    // A head may leave its FIFO when its target slot is free, or when it is dropped.
    function automatic logic head_ok(input flit_t f, input logic [NUM_PORTS-1:0] free);
        logic ok;
        case (get_dest(f))
            DEST_A:  ok = free[0];
            DEST_B:  ok = free[1];
            DEST_C:  ok = free[2];
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/router_if.sv
// Ingress stream plus the three egress streams of router_1x3, named from the
// router's point of view; master drives ingress and the egress readies.
interface router_if;
    import router_pkg::*;

    flit_t Data_i;
    logic  Valid_i;
    logic  Ready_o;
    flit_t DataA_o;
    logic  ValidA_o;
    logic  ReadyA_i;
    flit_t DataB_o;
    logic  ValidB_o;
    logic  ReadyB_i;
    flit_t DataC_o;
    logic  ValidC_o;
    logic  ReadyC_i;

    modport master (
        output Data_i, Valid_i, ReadyA_i, ReadyB_i, ReadyC_i,
        input  Ready_o, DataA_o, ValidA_o, DataB_o, ValidB_o, DataC_o, ValidC_o
    );

    modport slave (
        input  Data_i, Valid_i, ReadyA_i, ReadyB_i, ReadyC_i,
        output Ready_o, DataA_o, ValidA_o, DataB_o, ValidB_o, DataC_o, ValidC_o
    );

endinterface

// File: rtl/fifo_sync.sv
// Show-ahead synchronous FIFO; the extra pointer bit separates full from empty.
module fifo_sync #(
    parameter int unsigned Width     = 32,
    parameter int unsigned AddrWidth = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned Depth = 1 << AddrWidth;

    logic [Width-1:0]   mem_q [Depth];
    logic [AddrWidth:0] wr_ptr_q, wr_ptr_d;
    logic [AddrWidth:0] rd_ptr_q, rd_ptr_d;
    logic               do_wr, do_rd;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]) &&
                       (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[AddrWidth-1:0]];

    always_comb begin
        do_wr    = wr_en_i && !full_o;
        do_rd    = rd_en_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AddrWidth+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AddrWidth+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AddrWidth-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/router_1x3.sv
// 1x3 splitting router: flits are buffered per class, then dispatched into
// per-port output registers, priority first with regular bypass of a blocked head.
module router_1x3
    import router_pkg::*;
#(
    parameter int unsigned AddrWidth = ADDR_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    router_if.slave  bus,
    output logic     Drop_o
);

    flit_t                         reg_head, prio_head, pop_flit;
    logic                          reg_empty, reg_full, prio_empty, prio_full;
    logic                          wr_en, pop_reg, pop_prio;
    logic [NUM_PORTS-1:0]          ready_vec, slot_free, load;
    logic [NUM_PORTS-1:0]          valid_q, valid_d;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic                          drop_q, drop_d;

    assign bus.Ready_o = !rst && !reg_full && !prio_full;
    assign wr_en       = bus.Valid_i && bus.Ready_o;

    fifo_sync #(
        .Width     (DATA_WIDTH),
        .AddrWidth (AddrWidth)
    ) u_reg_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en && !bus.Data_i[PRIO_BIT]),
        .wr_data_i (bus.Data_i),
        .rd_en_i   (pop_reg),
        .rd_data_o (reg_head),
        .empty_o   (reg_empty),
        .full_o    (reg_full)
    );

    fifo_sync #(
        .Width     (DATA_WIDTH),
        .AddrWidth (AddrWidth)
    ) u_prio_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en && bus.Data_i[PRIO_BIT]),
        .wr_data_i (bus.Data_i),
        .rd_en_i   (pop_prio),
        .rd_data_o (prio_head),
        .empty_o   (prio_empty),
        .full_o    (prio_full)
    );

    assign ready_vec = {bus.ReadyC_i, bus.ReadyB_i, bus.ReadyA_i};
    assign slot_free = ~valid_q | ready_vec;

    // Dispatch: one pop per cycle, then load the target slot or flag a drop.
    always_comb begin
        pop_prio = 1'b0;
        pop_reg  = 1'b0;
        load     = '0;
        drop_d   = 1'b0;
        valid_d  = valid_q & ~ready_vec;
        data_d   = data_q;

        if (!prio_empty && head_ok(prio_head, slot_free)) begin
            pop_prio = 1'b1;
        end else if (!reg_empty && head_ok(reg_head, slot_free)) begin
            pop_reg = 1'b1;
        end
        pop_flit = pop_prio ? prio_head : reg_head;

        if (pop_prio || pop_reg) begin
            case (get_dest(pop_flit))
                DEST_A:  load[0] = 1'b1;
                DEST_B:  load[1] = 1'b1;
                DEST_C:  load[2] = 1'b1;
                default: drop_d  = 1'b1;
            endcase
        end

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (load[i]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = pop_flit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.DataA_o  = data_q[0];
    assign bus.DataB_o  = data_q[1];
    assign bus.DataC_o  = data_q[2];
    assign bus.ValidA_o = valid_q[0];
    assign bus.ValidB_o = valid_q[1];
    assign bus.ValidC_o = valid_q[2];
    assign Drop_o       = drop_q;

endmodule

// File: tb/tb_router_1x3.sv
// Scenario bench for router_1x3: expected flits are queued per port and
// checked by a monitor as each egress handshake completes.
module tb_router_1x3;
    import router_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drop_o;

    int vectors     = 0;
    int miscompares = 0;
    int drop_pend   = 0;

    flit_t exp_q [3][$];

    router_if bus ();

    router_1x3 dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .Drop_o (drop_o)
    );

    always #5 clk = ~clk;

    // Egress monitor: a flit leaves when valid and ready are both high at the edge.
    always @(negedge clk) begin
        logic [2:0] v, r;
        flit_t      d [3];
        flit_t      e;
        v = {bus.ValidC_o, bus.ValidB_o, bus.ValidA_o};
        r = {bus.ReadyC_i, bus.ReadyB_i, bus.ReadyA_i};
        d[0] = bus.DataA_o; d[1] = bus.DataB_o; d[2] = bus.DataC_o;
        if (!rst) begin
            for (int p = 0; p < 3; p++) begin
                if (v[p] && r[p]) begin
                    vectors++;
                    if (exp_q[p].size() == 0) begin
                        miscompares++;
                        $display("FAIL port%0d_unexpected: got %h, expected nothing", p, d[p]);
                    end else begin
                        e = exp_q[p].pop_front();
                        if (d[p] !== e) begin
                            miscompares++;
                            $display("FAIL port%0d_data: got %h, expected %h", p, d[p], e);
                        end
                    end
                end
            end
            if (drop_o) begin
                vectors++;
                if (drop_pend == 0) begin
                    miscompares++;
                    $display("FAIL drop_unexpected: got Drop_o=1, expected 0");
                end else begin
                    drop_pend--;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input flit_t d, input bit push, output int tries);
        bit ok;
        ok    = 1'b0;
        tries = 0;
        bus.Data_i  = d;
        bus.Valid_i = 1'b1;
        while (!ok && tries < 200) begin
            @(negedge clk);
            ok = bus.Ready_o;
            tries++;
            step();
        end
        bus.Valid_i = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: flit %h not accepted, expected acceptance", d);
        end else if (push) begin
            exp_q[get_dest(d)].push_back(d);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + drop_pend) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        step();
        vectors++;
        if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + drop_pend) != 0) begin
            miscompares++;
            $display("FAIL %s_drain: pending A=%0d B=%0d C=%0d drop=%0d, expected all 0",
                     name, exp_q[0].size(), exp_q[1].size(), exp_q[2].size(), drop_pend);
        end
    endtask

    task automatic set_ready(input logic a, input logic b, input logic c);
        bus.ReadyA_i = a;
        bus.ReadyB_i = b;
        bus.ReadyC_i = c;
    endtask

    task automatic test_reset();
        bus.Valid_i = 1'b0;
        bus.Data_i  = '0;
        set_ready(1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({bus.ValidA_o, bus.ValidB_o, bus.ValidC_o, drop_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_valid: got %b, expected 0000",
                     {bus.ValidA_o, bus.ValidB_o, bus.ValidC_o, drop_o});
        end
        vectors++;
        if ({bus.DataA_o, bus.DataB_o, bus.DataC_o} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h, expected zeros",
                     bus.DataA_o, bus.DataB_o, bus.DataC_o);
        end
        vectors++;
        if (bus.Ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_low: got %b, expected 0", bus.Ready_o);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.Ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_high: got %b, expected 1", bus.Ready_o);
        end
        step();
    endtask

    task automatic test_basic_route();
        int t;
        set_ready(1'b1, 1'b1, 1'b1);
        send(32'h0000_1234, 1'b1, t);
        @(negedge clk);
        vectors++;
        if (bus.ValidA_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_cycle1: got ValidA_o=%b, expected 0", bus.ValidA_o);
        end
        @(negedge clk);
        vectors++;
        if ({bus.ValidA_o, bus.ValidB_o, bus.ValidC_o, drop_o} !== 4'b1000 ||
            bus.DataA_o !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL basic_cycle2: got valid/drop=%b data=%h, expected 1000 00001234",
                     {bus.ValidA_o, bus.ValidB_o, bus.ValidC_o, drop_o}, bus.DataA_o);
        end
        @(negedge clk);
        vectors++;
        if (bus.ValidA_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_cycle3: got ValidA_o=%b, expected 0", bus.ValidA_o);
        end
        wait_drain("basic");
    endtask

    task automatic test_priority_overtake();
        int t;
        set_ready(1'b1, 1'b0, 1'b1);
        exp_q[1].push_back(32'h4000_0001);
        exp_q[1].push_back(32'h6000_00AA);
        exp_q[1].push_back(32'h4000_0002);
        exp_q[1].push_back(32'h4000_0003);
        send(32'h4000_0001, 1'b0, t);
        send(32'h4000_0002, 1'b0, t);
        send(32'h4000_0003, 1'b0, t);
        send(32'h6000_00AA, 1'b0, t);
        step();
        step();
        vectors++;
        if (bus.ValidB_o !== 1'b1 || bus.DataB_o !== 32'h4000_0001) begin
            miscompares++;
            $display("FAIL overtake_hold: got %b %h, expected 1 40000001",
                     bus.ValidB_o, bus.DataB_o);
        end
        bus.ReadyB_i = 1'b1;
        wait_drain("overtake");
    endtask

    task automatic test_bypass();
        int t;
        set_ready(1'b0, 1'b1, 1'b1);
        send(32'h0000_0004, 1'b1, t);
        send(32'h2000_0005, 1'b1, t);
        send(32'h8000_0007, 1'b1, t);
        for (int i = 0; i < 4; i++) step();
        vectors++;
        if (exp_q[2].size() != 0) begin
            miscompares++;
            $display("FAIL bypass_c: got %0d pending on C, expected 0", exp_q[2].size());
        end
        vectors++;
        if (bus.ValidA_o !== 1'b1 || bus.DataA_o !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL bypass_a_hold: got %b %h, expected 1 00000004",
                     bus.ValidA_o, bus.DataA_o);
        end
        bus.ReadyA_i = 1'b1;
        wait_drain("bypass");
    endtask

    task automatic test_backpressure();
        int t;
        set_ready(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(flit_t'(i), 1'b1, t);
            vectors++;
            if (t != 1) begin
                miscompares++;
                $display("FAIL bp_accept%0d: got %0d tries, expected 1", i, t);
            end
        end
        bus.Data_i  = 32'h0000_0005;
        bus.Valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.Ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_full%0d: got Ready_o=%b, expected 0", i, bus.Ready_o);
            end
        end
        vectors++;
        if (bus.ValidA_o !== 1'b1 || bus.DataA_o !== 32'h0) begin
            miscompares++;
            $display("FAIL bp_head: got %b %h, expected 1 00000000", bus.ValidA_o, bus.DataA_o);
        end
        step();
        bus.ReadyA_i = 1'b1;
        for (int i = 5; i < 20; i++) send(flit_t'(i), 1'b1, t);
        wait_drain("backpressure");
    endtask

    task automatic test_back_to_back();
        int    t;
        flit_t f;
        set_ready(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            f = {2'(i % 3), 1'(i[0]), 29'(32'h100 + i)};
            send(f, 1'b1, t);
            vectors++;
            if (t != 1) begin
                miscompares++;
                $display("FAIL b2b_accept%0d: got %0d tries, expected 1", i, t);
            end
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_drop();
        int t;
        set_ready(1'b1, 1'b1, 1'b1);
        drop_pend++;
        send(32'hC000_0099, 1'b0, t);
        @(negedge clk);
        vectors++;
        if (drop_o !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_cycle1: got %b, expected 0", drop_o);
        end
        @(negedge clk);
        vectors++;
        if ({drop_o, bus.ValidA_o, bus.ValidB_o, bus.ValidC_o} !== 4'b1000) begin
            miscompares++;
            $display("FAIL drop_cycle2: got drop/valids=%b, expected 1000",
                     {drop_o, bus.ValidA_o, bus.ValidB_o, bus.ValidC_o});
        end
        @(negedge clk);
        vectors++;
        if (drop_o !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_cycle3: got %b, expected 0", drop_o);
        end
        wait_drain("drop");
    endtask

    task automatic test_reset_midflight();
        int t;
        set_ready(1'b1, 1'b0, 1'b1);
        send(32'h4000_0010, 1'b0, t);
        send(32'h4000_0011, 1'b0, t);
        send(32'h4000_0012, 1'b0, t);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.Ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_ready_low: got %b, expected 0", bus.Ready_o);
        end
        step();
        rst = 1'b0;
        vectors++;
        if ({bus.ValidA_o, bus.ValidB_o, bus.ValidC_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_valid: got %b, expected 000",
                     {bus.ValidA_o, bus.ValidB_o, bus.ValidC_o});
        end
        @(negedge clk);
        vectors++;
        if (bus.Ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_ready_high: got %b, expected 1", bus.Ready_o);
        end
        step();
        bus.ReadyB_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.ValidA_o, bus.ValidB_o, bus.ValidC_o, drop_o} !== 4'b0000) begin
                miscompares++;
                $display("FAIL mid_stale%0d: got %b, expected 0000", i,
                         {bus.ValidA_o, bus.ValidB_o, bus.ValidC_o, drop_o});
            end
        end
        wait_drain("midflight");
    endtask

    initial begin
        test_reset();
        test_basic_route();
        test_priority_overtake();
        test_bypass();
        test_backpressure();
        test_back_to_back();
        test_drop();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
